// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and hazard controller: shadows the ID/EX, EX/MEM and MEM/WB destination
// info, produces registered EX operand selects and load-use / HI/LO stall requests.
module fwd_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MDU_LAT    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  mem_stall_i,
  input  logic                  id_valid_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rs_i,
  input  logic                  id_uses_rt_i,
  input  logic                  id_wreg_i,
  input  logic [REG_ADDR_W-1:0] id_waddr_i,
  input  logic                  id_is_load_i,
  input  logic                  id_is_mdu_i,
  input  logic                  id_reads_hilo_i,
  output logic [1:0]            forwardA_o,
  output logic [1:0]            forwardB_o,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic                  mdu_busy_o
);

  localparam int CNT_W = $clog2(MDU_LAT + 1);

  typedef struct packed {
    logic                  valid;
    logic                  wreg;
    logic [REG_ADDR_W-1:0] waddr;
    logic                  is_load;
  } entry_t;

  localparam entry_t BUBBLE = '0;

  entry_t           s_ex_q, s_ex_d;
  entry_t           s_mem_q, s_mem_d;
  entry_t           s_wb_q, s_wb_d;
  logic [1:0]       fwd_a_q, fwd_a_d;
  logic [1:0]       fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic load_use_s;
  logic hilo_haz_s;
  logic hazard_s;

  // Register 0 never matches; load_only restricts the match to load producers.
  function automatic logic hit_f(entry_t e, logic [REG_ADDR_W-1:0] a, logic load_only);
    return e.valid && e.wreg && (e.waddr == a) && (a != '0) && (!load_only || e.is_load);
  endfunction

  // Newest producer wins; a WB-stage producer is covered by register file write-through.
  function automatic logic [1:0] sel_f(entry_t ex, entry_t mem, entry_t wb,
                                       logic [REG_ADDR_W-1:0] a);
    logic [1:0] sel;
    if (hit_f(ex, a, 1'b0)) begin
      sel = 2'b01;
    end else if (hit_f(mem, a, 1'b0)) begin
      sel = 2'b10;
    end else if (hit_f(wb, a, 1'b0)) begin
      sel = 2'b00;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign mdu_busy_o = (cnt_q != '0);

  // Hazard detection and stall/bubble requests
  always_comb begin
    load_use_s = id_valid_i &&
                 ((id_uses_rs_i && hit_f(s_ex_q, id_rs_i, 1'b1)) ||
                  (id_uses_rt_i && hit_f(s_ex_q, id_rt_i, 1'b1)));
    hilo_haz_s = id_valid_i && mdu_busy_o && (id_reads_hilo_i || id_is_mdu_i);
    hazard_s   = load_use_s || hilo_haz_s;
    if (!rst_n_i) begin
      stall_o = 1'b0;
      flush_o = 1'b0;
    end else if (mem_stall_i) begin
      stall_o = 1'b1;
      flush_o = 1'b0;
    end else begin
      stall_o = hazard_s;
      flush_o = hazard_s;
    end
  end

  // Next state: shadow shift, select capture and MDU countdown unless frozen
  always_comb begin
    s_ex_d  = s_ex_q;
    s_mem_d = s_mem_q;
    s_wb_d  = s_wb_q;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    cnt_d   = cnt_q;
    if (!mem_stall_i) begin
      s_wb_d  = s_mem_q;
      s_mem_d = s_ex_q;
      if (hazard_s || !id_valid_i) begin
        s_ex_d  = BUBBLE;
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
      end else begin
        s_ex_d  = '{valid: 1'b1, wreg: id_wreg_i, waddr: id_waddr_i, is_load: id_is_load_i};
        fwd_a_d = id_uses_rs_i ? sel_f(s_ex_q, s_mem_q, s_wb_q, id_rs_i) : 2'b00;
        fwd_b_d = id_uses_rt_i ? sel_f(s_ex_q, s_mem_q, s_wb_q, id_rt_i) : 2'b00;
      end
      if (id_valid_i && id_is_mdu_i && !hazard_s) begin
        cnt_d = CNT_W'(MDU_LAT);
      end else if (cnt_q != '0) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s_ex_q  <= BUBBLE;
      s_mem_q <= BUBBLE;
      s_wb_q  <= BUBBLE;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      s_ex_q  <= s_ex_d;
      s_mem_q <= s_mem_d;
      s_wb_q  <= s_wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign forwardA_o = fwd_a_q;
  assign forwardB_o = fwd_b_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl: pipeline instruction sequences with hand-computed
// forward selects, stall/flush and MDU busy expectations.
module tb_fwd_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       mem_stall;
  logic       id_valid;
  logic [4:0] id_rs, id_rt, id_waddr;
  logic       id_uses_rs, id_uses_rt, id_wreg, id_is_load, id_is_mdu, id_reads_hilo;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, flush, busy;

  int checks   = 0;
  int failures = 0;

  fwd_hazard_ctrl #(.REG_ADDR_W(5), .MDU_LAT(4)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .mem_stall_i    (mem_stall),
    .id_valid_i     (id_valid),
    .id_rs_i        (id_rs),
    .id_rt_i        (id_rt),
    .id_uses_rs_i   (id_uses_rs),
    .id_uses_rt_i   (id_uses_rt),
    .id_wreg_i      (id_wreg),
    .id_waddr_i     (id_waddr),
    .id_is_load_i   (id_is_load),
    .id_is_mdu_i    (id_is_mdu),
    .id_reads_hilo_i(id_reads_hilo),
    .forwardA_o     (fwd_a),
    .forwardB_o     (fwd_b),
    .stall_o        (stall),
    .flush_o        (flush),
    .mdu_busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic wr,
                       input logic [4:0] wa, input logic ld, input logic mdu,
                       input logic hilo);
    id_valid = v; id_rs = rs; id_rt = rt; id_uses_rs = urs; id_uses_rt = urt;
    id_wreg = wr; id_waddr = wa; id_is_load = ld; id_is_mdu = mdu; id_reads_hilo = hilo;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    repeat (4) tick();
  endtask

  initial begin
    int  busy_cycles;
    logic done;
    rst_n = 1'b0;
    mem_stall = 1'b0;
    nop();
    chk("rst_fwdA", {6'd0, fwd_a}, 8'h00);
    chk("rst_fwdB", {6'd0, fwd_b}, 8'h00);
    chk("rst_stall", {7'd0, stall}, 8'h00);
    chk("rst_flush", {7'd0, flush}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    tick();
    rst_n = 1'b1;

    // add r3,r1,r2 ; sub r4,r3,r5
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    chk("b2b_stall", {7'd0, stall}, 8'h00);
    tick();
    chk("b2b_fwdA", {6'd0, fwd_a}, 8'h01);
    chk("b2b_fwdB", {6'd0, fwd_b}, 8'h00);
    drain();

    // add r3 ; nop ; or r6,r7,r3
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    tick();
    nop();
    tick();
    drive(1'b1, 5'd7, 5'd3, 1'b1, 1'b1, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
    tick();
    chk("d2_fwdA", {6'd0, fwd_a}, 8'h00);
    chk("d2_fwdB", {6'd0, fwd_b}, 8'h02);
    drain();

    // add r3 ; addi r3,r1 ; sub r4,r3,r3
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd3, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
    chk("dbl_stall", {7'd0, stall}, 8'h00);
    tick();
    chk("dbl_fwdA", {6'd0, fwd_a}, 8'h01);
    chk("dbl_fwdB", {6'd0, fwd_b}, 8'h01);
    drain();

    // lw r8,0(r1) ; add r9,r8,r1
    drive(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    chk("lu_stall", {7'd0, stall}, 8'h01);
    chk("lu_flush", {7'd0, flush}, 8'h01);
    tick();
    chk("lu_bubble_fwdA", {6'd0, fwd_a}, 8'h00);
    chk("lu_stall2", {7'd0, stall}, 8'h00);
    chk("lu_flush2", {7'd0, flush}, 8'h00);
    tick();
    chk("lu_fwdA", {6'd0, fwd_a}, 8'h02);
    chk("lu_fwdB", {6'd0, fwd_b}, 8'h00);
    drain();

    // addi r0 ; add r1,r0,r0 and lw r0 ; add r1,r0,r0
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    chk("r0_stall", {7'd0, stall}, 8'h00);
    tick();
    chk("r0_fwdA", {6'd0, fwd_a}, 8'h00);
    chk("r0_fwdB", {6'd0, fwd_b}, 8'h00);
    drive(1'b1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    chk("r0_load_stall", {7'd0, stall}, 8'h00);
    drain();

    // mult r1,r2 ; mflo r10
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    chk("mdu_idle", {7'd0, busy}, 8'h00);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("mdu_busy_%0d", k), {7'd0, busy}, 8'h01);
      chk($sformatf("mdu_stall_%0d", k), {7'd0, stall}, 8'h01);
      chk($sformatf("mdu_flush_%0d", k), {7'd0, flush}, 8'h01);
      tick();
    end
    chk("mdu_done_busy", {7'd0, busy}, 8'h00);
    chk("mdu_done_stall", {7'd0, stall}, 8'h00);
    drain();

    // mult ; mflo with a 2-cycle memory freeze inside the busy window
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b0, 1'b1);
    busy_cycles = 0;
    done = 1'b0;
    for (int c = 0; c < 20; c++) begin
      mem_stall = (c == 1 || c == 2);
      #1;
      if (!busy) begin
        done = 1'b1;
        break;
      end
      busy_cycles++;
      chk($sformatf("ms_stall_%0d", c), {7'd0, stall}, 8'h01);
      chk($sformatf("ms_flush_%0d", c), {7'd0, flush}, {7'd0, ~mem_stall});
      tick();
    end
    mem_stall = 1'b0;
    chk("ms_timeout", {7'd0, done}, 8'h01);
    chk("ms_busy_cycles", busy_cycles[7:0], 8'd6);
    chk("ms_release_stall", {7'd0, stall}, 8'h00);
    drain();

    // reset during load-use stall with a pending forward
    drive(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 5'd0, 1'b1, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rm_pre_fwdA", {6'd0, fwd_a}, 8'h01);
    drive(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0);
    chk("rm_pre_stall", {7'd0, stall}, 8'h01);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rm_fwdA", {6'd0, fwd_a}, 8'h00);
    chk("rm_stall", {7'd0, stall}, 8'h00);
    chk("rm_flush", {7'd0, flush}, 8'h00);
    #2;
    rst_n = 1'b1;
    #1;
    chk("rm_post_stall", {7'd0, stall}, 8'h00);
    tick();
    chk("rm_post_fwdA", {6'd0, fwd_a}, 8'h00);
    chk("rm_post_fwdB", {6'd0, fwd_b}, 8'h00);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fwd_hazard_ctrl.md
# fwd_hazard_ctrl

Forwarding and hazard controller for the 5-stage pipeline. It generates the registered 2-bit operand-source selects consumed by the EX-stage operand forwarding mux: 00 selects the register file, 01 the EX/MEM ALU result, 10 the MEM/WB write-back data. It keeps its own shadow copies of destination-register info for the ID/EX, EX/MEM and MEM/WB stages. It raises stall and bubble requests for load-use hazards and for HI/LO reads while the multi-cycle multiply/divide unit (MDU) is busy.

## Interface
Parameters:
- REG_ADDR_W, 5, register address width
- MDU_LAT, 4, MDU busy cycles after issue (≥1)

Ports:
- clk_i  in  1  clock, rising edge
- rst_n_i  in  1  reset; asynchronous, active-low
- mem_stall_i  in  1  global freeze from memory; all state holds
- id_valid_i  in  1  ID holds a real instruction
- id_rs_i / id_rt_i  in  REG_ADDR_W  source register addresses
- id_uses_rs_i / id_uses_rt_i  in  1  operand actually read
- id_wreg_i  in  1  instruction writes a GPR
- id_waddr_i  in  REG_ADDR_W  destination GPR
- id_is_load_i  in  1  instruction is a load
- id_is_mdu_i  in  1  instruction starts a mult/div
- id_reads_hilo_i  in  1  instruction reads HI/LO (mfhi/mflo)
- forwardA_o / forwardB_o  out  2  registered selects for EX operand 1/2
- stall_o  out  1  hold PC and IF/ID
- flush_o  out  1  insert bubble into ID/EX
- mdu_busy_o  out  1  MDU counter non-zero

## Operation
- Shadow entries S_EX, S_MEM and S_WB each hold {valid, wreg, waddr, is_load}. On every non-frozen edge they shift: ID→S_EX, S_EX→S_MEM, S_MEM→S_WB.
- "Match(x)": entry valid && wreg && waddr==x && x!=0. Register 0 is never forwarded or stalled on.
- Load-use hazard: id_valid_i && S_EX.is_load && (Match on rs with uses_rs, or Match on rt with uses_rt).
- HI/LO hazard: id_valid_i && mdu_busy_o && (id_reads_hilo_i || id_is_mdu_i).
- Hazard = load-use OR HI/LO. Then stall_o=flush_o=1, and S_EX loads a bubble (valid=0).
- Forward select for rs, computed in ID and captured into forwardA_o:
  - Match in S_EX gives 01 (the producer will be in MEM when the consumer is in EX).
  - Otherwise, Match in S_MEM gives 10.
  - Otherwise 00.
  - S_EX has priority over S_MEM (newest wins).
  - rt and forwardB_o use identical logic.
  - 11 is never produced.
- A producer in S_WB is not forwarded; the register file write-through covers it, so the select is 00.
- If the operand is unused (uses_*=0), or there is a bubble or hazard, the select captured is 00.
- MDU counter:
  - Loads MDU_LAT when a non-stalled id_is_mdu_i instruction advances.
  - Otherwise decrements while non-zero.
  - mdu_busy_o = (count != 0).
- mem_stall_i=1 freezes everything:
  - Shadows, selects and the counter all hold; the counter does not decrement.
  - stall_o=1, flush_o=0.

## Timing
- Reset (async assert, sync release):
  - All shadows invalid.
  - forwardA_o=forwardB_o=00.
  - stall_o=flush_o=0.
  - Counter=0, so mdu_busy_o=0.
- stall_o and flush_o are combinational from the ID inputs and current state, valid in the same cycle.
- Forward selects are registered: the instruction in ID in cycle n gets its selects on forwardA_o/forwardB_o in cycle n+1, while it is in EX.
- Load-use stall lasts exactly 1 cycle:
  - The next cycle the load is in S_MEM, and the consumer is granted 10.
- HI/LO stall persists until the counter reaches 0; the stalled instruction proceeds in the cycle mdu_busy_o=0.
- Simultaneous mem_stall_i and a hazard: mem_stall_i wins. No bubble is inserted; the hazard is re-evaluated after release.
- Reset asserted mid-stall clears the stall immediately; any pending forward is discarded.

## Test plan
- Back-to-back ALU dependency: `add r3,r1,r2` then `sub r4,r3,r5`. forwardA_o=01 in sub's EX cycle; no stall.
- Distance-2 dependency with rt: `add r3`, nop, `or r6,r7,r3`. forwardB_o=10.
- Double producer: `add r3`, `addi r3`, `sub r4,r3,r3`. Both selects are 01, from the newer producer.
- Load-use: `lw r8` then `add r9,r8,r1`.
  - One cycle with stall_o=flush_o=1.
  - Then forwardA_o=10.
  - A write to r0 followed by a read of r0 gives 00 and no stall.
- MDU, with MDU_LAT=4: `mult` then `mflo`.
  - mdu_busy_o is high for 4 cycles, and mflo stalls until it drops.
  - mem_stall_i asserted for 2 of those cycles extends the busy window by 2.
- Reset mid-hazard: assert rst_n_i=0 during a load-use stall. Outputs go to 00/0 asynchronously, and all shadows are invalid after release.
